// File: rtl/generator_addr_out.sv
// Write-side tile address generator: takes 16 result words of a 4x4 tile
// and issues registered row-major writes to the output buffer.
module generator_addr_out #(
  parameter int END_ROW     = 16,
  parameter int TILE_STRIDE = 64,
  parameter int HEIGHT      = 256,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        i,
  input  logic [7:0]        j,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  col;
  logic [1:0]  row;
  logic [7:0]  i_q;
  logic [7:0]  j_q;
  logic        accept;
  logic        last;
  logic [17:0] addr_full;

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = WRITE;
      end
      WRITE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        last     = in_valid && (row == 2'd3) && (col == 2'd3);
        if (last) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Wide enough for the largest tile base; truncation gives the modulo wrap.
  assign addr_full = 18'(TILE_STRIDE) * 18'(i_q)
                   + 18'(j_q) * 18'd4
                   + 18'(END_ROW) * 18'(row)
                   + 18'(col);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      wr_en <= accept;
      done  <= last;
      if (state == IDLE && start) begin
        i_q <= i;
        j_q <= j;
        col <= '0;
        row <= '0;
      end
      if (accept) begin
        wr_addr <= addr_full[ADDR_W-1:0];
        wr_data <= in_data;
        col     <= col + 2'd1;
        if (col == 2'd3) row <= row + 2'd1;
      end
    end
  end

endmodule
